// File: rtl/gbc_dma_arbiter.sv
// Shared-bus arbiter for the CPU, the HDMA engine and the OAM DMA engine.
// Each DMA byte is a read slot followed by a write slot; ownership changes only between bytes.
module gbc_dma_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        hdma_rd,
    input  logic [15:0] hdma_src,
    input  logic [15:0] hdma_dst,
    input  logic        oam_req,
    input  logic [15:0] oam_src,
    input  logic [7:0]  oam_idx,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic [7:0]  bus_rdata,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic        vram_we,
    output logic [12:0] vram_addr,
    output logic [7:0]  vram_wdata,
    output logic        oam_we,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        hdma_ack,
    output logic        oam_ack,
    output logic        cpu_stall,
    output logic [1:0]  grant
);

    typedef enum logic [2:0] {IDLE, H_RD, H_WR, O_RD, O_WR} state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  grant_next;
    logic [12:0] hdma_dst_q;
    logic        hdma_vram_q;
    logic [7:0]  oam_idx_q;
    logic        cpu_hram;
    logic        cpu_bus;
    logic        hdma_src_vram;

    // HRAM/IE accesses are served inside the CPU and never touch the shared bus.
    assign cpu_hram      = (cpu_addr >= 16'hFF80);
    assign cpu_bus       = cpu_req & ~cpu_hram;
    assign hdma_src_vram = (hdma_src[15:13] == 3'b100);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= 2'd0;
            hdma_dst_q  <= '0;
            hdma_vram_q <= 1'b0;
            oam_idx_q   <= '0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            if (state == H_RD) begin
                hdma_dst_q  <= hdma_dst[12:0];
                hdma_vram_q <= hdma_src_vram;
            end
            if (state == O_RD) begin
                oam_idx_q <= oam_idx;
            end
        end
    end

    // The continuation rules from H_WR and O_WR coincide with plain priority arbitration,
    // so every byte boundary (IDLE, H_WR, O_WR) uses the same decision.
    always_comb begin
        state_next = IDLE;
        case (state)
            H_RD:    state_next = H_WR;
            O_RD:    state_next = O_WR;
            default: begin
                if (hdma_rd) begin
                    state_next = H_RD;
                end else if (oam_req) begin
                    state_next = O_RD;
                end else begin
                    state_next = IDLE;
                end
            end
        endcase

        grant_next = 2'd0;
        case (state_next)
            H_RD, H_WR: grant_next = 2'd1;
            O_RD, O_WR: grant_next = 2'd2;
            default:    grant_next = 2'd0;
        endcase
    end

    always_comb begin
        bus_addr   = '0;
        bus_wdata  = '0;
        bus_rd     = 1'b0;
        bus_wr     = 1'b0;
        vram_we    = 1'b0;
        vram_wdata = '0;
        oam_we     = 1'b0;
        oam_wdata  = '0;
        hdma_ack   = 1'b0;
        oam_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_bus) begin
                    bus_addr  = cpu_addr;
                    bus_wdata = cpu_wdata;
                    bus_rd    = ~cpu_wr;
                    bus_wr    = cpu_wr;
                end
            end
            H_RD: begin
                bus_addr = hdma_src;
                bus_rd   = ~hdma_src_vram;
            end
            H_WR: begin
                bus_addr   = hdma_src;
                vram_we    = 1'b1;
                vram_wdata = hdma_vram_q ? 8'hFF : bus_rdata;
                hdma_ack   = 1'b1;
            end
            O_RD: begin
                bus_addr = oam_src;
                bus_rd   = 1'b1;
            end
            O_WR: begin
                bus_addr  = oam_src;
                oam_we    = 1'b1;
                oam_wdata = bus_rdata;
                oam_ack   = 1'b1;
            end
            default: begin
                bus_addr = '0;
            end
        endcase
    end

    assign vram_addr = hdma_dst_q;
    assign oam_addr  = oam_idx_q;
    assign cpu_stall = cpu_bus & (grant != 2'd0);

endmodule

// File: tb/tb_gbc_dma_arbiter.sv
// Bench for gbc_dma_arbiter: per-cycle stimulus tables, a byte-slot schedule model and a bus memory model.
module tb_gbc_dma_arbiter;
    localparam int MAXC = 80;

    logic        clk = 1'b0;
    logic        reset;
    logic        hdma_rd, oam_req, cpu_req, cpu_wr;
    logic [15:0] hdma_src, hdma_dst, oam_src, cpu_addr;
    logic [7:0]  oam_idx, cpu_wdata;
    logic [7:0]  bus_rdata = 8'h00;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata, vram_wdata, oam_addr, oam_wdata;
    logic        bus_rd, bus_wr, vram_we, oam_we, hdma_ack, oam_ack, cpu_stall;
    logic [12:0] vram_addr;
    logic [1:0]  grant;

    int checks = 0;
    int failures = 0;
    logic [7:0] seed;

    logic        hreq [MAXC], oreq [MAXC], creq [MAXC], cwr [MAXC], rst [MAXC];
    logic [15:0] hsrc [MAXC], hdst [MAXC], osrc [MAXC], caddr [MAXC];
    logic [7:0]  oidx [MAXC], cwdata [MAXC];

    logic [1:0]  ob_grant [MAXC];
    logic        ob_vwe [MAXC], ob_owe [MAXC], ob_hack [MAXC], ob_oack [MAXC];
    logic        ob_stall [MAXC], ob_brd [MAXC], ob_bwr [MAXC];
    logic [12:0] ob_vaddr [MAXC];
    logic [7:0]  ob_vdata [MAXC], ob_oaddr [MAXC], ob_odata [MAXC];
    logic [15:0] ob_baddr [MAXC];

    int          exp_owner [MAXC];
    logic        exp_rd [MAXC], exp_vwe [MAXC], exp_owe [MAXC];
    logic [12:0] exp_vaddr [MAXC];
    logic [7:0]  exp_vdata [MAXC], exp_oaddr [MAXC], exp_odata [MAXC];

    gbc_dma_arbiter dut (
        .clk(clk), .reset(reset),
        .hdma_rd(hdma_rd), .hdma_src(hdma_src), .hdma_dst(hdma_dst),
        .oam_req(oam_req), .oam_src(oam_src), .oam_idx(oam_idx),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .bus_rdata(bus_rdata), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rd(bus_rd), .bus_wr(bus_wr),
        .vram_we(vram_we), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
        .oam_we(oam_we), .oam_addr(oam_addr), .oam_wdata(oam_wdata),
        .hdma_ack(hdma_ack), .oam_ack(oam_ack), .cpu_stall(cpu_stall), .grant(grant)
    );

    always #5 clk = ~clk;

    // Contents of the shared bus as seen by any reader.
    function automatic logic [7:0] memf(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ seed;
    endfunction

    always @(posedge clk) bus_rdata <= bus_rd ? memf(bus_addr) : 8'($urandom);

    task automatic clear_stim();
        for (int c = 0; c < MAXC; c++) begin
            hreq[c] = 0; oreq[c] = 0; creq[c] = 0; cwr[c] = 0; rst[c] = 0;
            hsrc[c] = 16'h0000; hdst[c] = 16'h8000; osrc[c] = 16'h0000;
            caddr[c] = 16'h0000; oidx[c] = 8'h00; cwdata[c] = 8'h00;
        end
    endtask

    task automatic do_reset();
        reset = 1; hdma_rd = 0; oam_req = 0; cpu_req = 0; cpu_wr = 0;
        hdma_src = 0; hdma_dst = 0; oam_src = 0; oam_idx = 0; cpu_addr = 0; cpu_wdata = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            reset = rst[c]; hdma_rd = hreq[c]; hdma_src = hsrc[c]; hdma_dst = hdst[c];
            oam_req = oreq[c]; oam_src = osrc[c]; oam_idx = oidx[c];
            cpu_req = creq[c]; cpu_wr = cwr[c]; cpu_addr = caddr[c]; cpu_wdata = cwdata[c];
            #4;
            ob_grant[c] = grant; ob_vwe[c] = vram_we; ob_owe[c] = oam_we;
            ob_hack[c] = hdma_ack; ob_oack[c] = oam_ack; ob_stall[c] = cpu_stall;
            ob_brd[c] = bus_rd; ob_bwr[c] = bus_wr; ob_vaddr[c] = vram_addr;
            ob_vdata[c] = vram_wdata; ob_oaddr[c] = oam_addr; ob_odata[c] = oam_wdata;
            ob_baddr[c] = bus_addr;
            @(posedge clk);
            #1;
        end
        reset = 0;
    endtask

    // Byte-slot schedule: cycle 0 is idle; at each boundary the highest requester takes the next two slots.
    task automatic build_model(input int n);
        int c;
        int nxt;
        for (int i = 0; i < MAXC; i++) begin
            exp_owner[i] = 0; exp_rd[i] = 0; exp_vwe[i] = 0; exp_owe[i] = 0;
            exp_vaddr[i] = 0; exp_vdata[i] = 0; exp_oaddr[i] = 0; exp_odata[i] = 0;
        end
        c = 0;
        while (c < n && c + 2 < MAXC) begin
            nxt = hreq[c] ? 1 : (oreq[c] ? 2 : 0);
            if (nxt == 0) begin
                c = c + 1;
            end else begin
                exp_owner[c + 1] = nxt; exp_owner[c + 2] = nxt; exp_rd[c + 1] = 1;
                if (nxt == 1) begin
                    exp_vwe[c + 2]   = 1;
                    exp_vaddr[c + 2] = hdst[c + 1][12:0];
                    exp_vdata[c + 2] = (hsrc[c + 1][15:13] == 3'b100) ? 8'hFF : memf(hsrc[c + 1]);
                end else begin
                    exp_owe[c + 2]   = 1;
                    exp_oaddr[c + 2] = oidx[c + 1];
                    exp_odata[c + 2] = memf(osrc[c + 1]);
                end
                c = c + 2;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        #4;
        checks++;
        if (grant !== 2'd0 || vram_we !== 0 || oam_we !== 0 || hdma_ack !== 0 || oam_ack !== 0) begin
            failures++;
            $display("[TB] FAIL reset_owner grant=%0d vwe=%b owe=%b hack=%b oack=%b required all 0",
                     grant, vram_we, oam_we, hdma_ack, oam_ack);
        end
        checks++;
        if (bus_rd !== 0 || bus_wr !== 0 || cpu_stall !== 0 || bus_addr !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset_bus rd=%b wr=%b stall=%b addr=%h required 0 0 0 0000",
                     bus_rd, bus_wr, cpu_stall, bus_addr);
        end
        checks++;
        if (vram_addr !== 13'h0 || oam_addr !== 8'h0) begin
            failures++;
            $display("[TB] FAIL reset_captures vaddr=%h oaddr=%h required 0", vram_addr, oam_addr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_hdma_block();
        int nw;
        logic [15:0] ca;
        clear_stim();
        for (int c = 0; c < 36; c++) begin
            hreq[c] = (c < 32);
            hsrc[c] = 16'h2040 + 16'((c == 0) ? 0 : (c - 1) >> 1);
            hdst[c] = 16'h8200 + 16'((c == 0) ? 0 : (c - 1) >> 1);
            ca = ($urandom_range(0, 3) == 0) ? 16'hFF80 + 16'($urandom_range(0, 127))
                                             : 16'($urandom_range(0, 16'hFF7F));
            creq[c] = 1'($urandom_range(0, 1)); cwr[c] = 1'($urandom_range(0, 1)); caddr[c] = ca;
        end
        build_model(36);
        do_reset();
        run(36);
        nw = 0;
        for (int c = 0; c < 36; c++) begin
            if (ob_vwe[c] === 1'b1) nw++;
            checks++;
            if (ob_grant[c] !== 2'(exp_owner[c]) || ob_vwe[c] !== exp_vwe[c] || ob_hack[c] !== exp_vwe[c]) begin
                failures++;
                $display("[TB] FAIL hdma_block_slot c=%0d grant=%0d vwe=%b hack=%b required %0d %b %b",
                         c, ob_grant[c], ob_vwe[c], ob_hack[c], exp_owner[c], exp_vwe[c], exp_vwe[c]);
            end
            if (exp_vwe[c]) begin
                checks++;
                if (ob_vaddr[c] !== exp_vaddr[c] || ob_vdata[c] !== exp_vdata[c]) begin
                    failures++;
                    $display("[TB] FAIL hdma_block_write c=%0d addr=%h data=%h required %h %h",
                             c, ob_vaddr[c], ob_vdata[c], exp_vaddr[c], exp_vdata[c]);
                end
            end
            checks++;
            if (ob_stall[c] !== (creq[c] && caddr[c] < 16'hFF80 && c >= 1 && c <= 32)) begin
                failures++;
                $display("[TB] FAIL hdma_block_stall c=%0d stall=%b req=%b addr=%h", c, ob_stall[c], creq[c], caddr[c]);
            end
        end
        checks++;
        if (nw != 16 || ob_vaddr[2] !== 13'h0200 || ob_vaddr[32] !== 13'h020F) begin
            failures++;
            $display("[TB] FAIL hdma_block_count writes=%0d first=%h last=%h required 16 0200 020F",
                     nw, ob_vaddr[2], ob_vaddr[32]);
        end
    endtask

    task automatic test_oam_preempt();
        int no;
        clear_stim();
        for (int c = 0; c < 15; c++) begin
            oreq[c] = (c < 12); hreq[c] = (c == 5 || c == 6);
            osrc[c] = 16'($urandom); oidx[c] = 8'($urandom_range(0, 8'h9F));
            hsrc[c] = 16'h4123; hdst[c] = 16'h9ABC;
        end
        build_model(15);
        do_reset();
        run(15);
        checks++;
        if (ob_oack[6] !== 1'b1 || ob_grant[7] !== 2'd1 || ob_vwe[8] !== 1'b1 || ob_grant[9] !== 2'd2 || ob_grant[13] !== 2'd0) begin
            failures++;
            $display("[TB] FAIL oam_preempt_order oack6=%b grant7=%0d vwe8=%b grant9=%0d grant13=%0d required 1 1 1 2 0",
                     ob_oack[6], ob_grant[7], ob_vwe[8], ob_grant[9], ob_grant[13]);
        end
        no = 0;
        for (int c = 0; c < 15; c++) begin
            if (ob_owe[c] === 1'b1) no++;
            if (exp_owe[c]) begin
                checks++;
                if (ob_owe[c] !== 1'b1 || ob_oaddr[c] !== exp_oaddr[c] || ob_odata[c] !== exp_odata[c]) begin
                    failures++;
                    $display("[TB] FAIL oam_preempt_write c=%0d we=%b addr=%h data=%h required 1 %h %h",
                             c, ob_owe[c], ob_oaddr[c], ob_odata[c], exp_oaddr[c], exp_odata[c]);
                end
            end
        end
        checks++;
        if (no != 5) begin
            failures++;
            $display("[TB] FAIL oam_preempt_count writes=%0d required 5", no);
        end
    endtask

    task automatic test_vram_src();
        int nw;
        clear_stim();
        for (int c = 0; c < 11; c++) begin
            hreq[c] = (c < 8);
            hsrc[c] = 16'h8000 | 16'($urandom_range(0, 16'h1FFF));
            hdst[c] = 16'h8000 | 16'($urandom_range(0, 16'h1FFF));
        end
        do_reset();
        run(11);
        nw = 0;
        for (int c = 0; c < 11; c++) begin
            checks++;
            if (ob_brd[c] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL vram_src_busrd c=%0d bus_rd=%b required 0", c, ob_brd[c]);
            end
            if (ob_vwe[c] === 1'b1) begin
                nw++;
                checks++;
                if (ob_vdata[c] !== 8'hFF) begin
                    failures++;
                    $display("[TB] FAIL vram_src_data c=%0d data=%h required ff", c, ob_vdata[c]);
                end
            end
        end
        checks++;
        if (nw != 4) begin
            failures++;
            $display("[TB] FAIL vram_src_count writes=%0d required 4", nw);
        end
    endtask

    task automatic test_cpu_hram();
        logic [15:0] s;
        s = 16'($urandom_range(16'h0100, 16'hDFFF));
        clear_stim();
        for (int c = 0; c < 12; c++) begin
            oreq[c] = (c < 10); osrc[c] = s; oidx[c] = 8'(c);
            creq[c] = 1; caddr[c] = (c < 5) ? 16'hFF90 : 16'hC000;
        end
        do_reset();
        run(12);
        checks++;
        if (ob_stall[0] !== 1'b0 || ob_brd[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hram_idle stall=%b bus_rd=%b required 0 0", ob_stall[0], ob_brd[0]);
        end
        for (int c = 1; c < 5; c++) begin
            checks++;
            if (ob_stall[c] !== 1'b0 || ob_baddr[c] !== s) begin
                failures++;
                $display("[TB] FAIL hram_during_oam c=%0d stall=%b addr=%h required 0 %h", c, ob_stall[c], ob_baddr[c], s);
            end
        end
        for (int c = 5; c < 11; c++) begin
            checks++;
            if (ob_stall[c] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL wram_stall c=%0d stall=%b required 1", c, ob_stall[c]);
            end
        end
        checks++;
        if (ob_stall[11] !== 1'b0 || ob_brd[11] !== 1'b1 || ob_baddr[11] !== 16'hC000) begin
            failures++;
            $display("[TB] FAIL wram_release stall=%b rd=%b addr=%h required 0 1 c000", ob_stall[11], ob_brd[11], ob_baddr[11]);
        end
    endtask

    task automatic test_drop_in_rd();
        logic [15:0] s;
        s = 16'h4000 | 16'($urandom_range(0, 16'h1FFF));
        clear_stim();
        hreq[0] = 1;
        for (int c = 0; c < 5; c++) begin
            hsrc[c] = s; hdst[c] = 16'h8123;
        end
        creq[3] = 1; caddr[3] = 16'hC000;
        do_reset();
        run(5);
        checks++;
        if (ob_vwe[2] !== 1'b1 || ob_hack[2] !== 1'b1 || ob_vdata[2] !== memf(s) || ob_vaddr[2] !== 13'h0123) begin
            failures++;
            $display("[TB] FAIL drop_in_rd_write vwe=%b hack=%b data=%h addr=%h required 1 1 %h 0123",
                     ob_vwe[2], ob_hack[2], ob_vdata[2], ob_vaddr[2], memf(s));
        end
        checks++;
        if (ob_grant[3] !== 2'd0 || ob_stall[3] !== 1'b0 || ob_brd[3] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL drop_in_rd_idle grant=%0d stall=%b rd=%b required 0 0 1", ob_grant[3], ob_stall[3], ob_brd[3]);
        end
    endtask

    task automatic test_reset_mid();
        int nw;
        clear_stim();
        for (int c = 0; c < 4; c++) begin
            hreq[c] = 1; hsrc[c] = 16'h1234; hdst[c] = 16'h8777;
        end
        rst[3] = 1;
        do_reset();
        run(7);
        nw = 0;
        for (int c = 0; c < 7; c++) if (ob_vwe[c] === 1'b1) nw++;
        checks++;
        if (ob_grant[4] !== 2'd0 || ob_vwe[4] !== 1'b0 || ob_hack[4] !== 1'b0 || nw != 1) begin
            failures++;
            $display("[TB] FAIL reset_mid grant=%0d vwe=%b hack=%b writes=%0d required 0 0 0 1",
                     ob_grant[4], ob_vwe[4], ob_hack[4], nw);
        end
    endtask

    task automatic test_random();
        localparam int N = 64;
        logic hon, oon, hram, exp_brd, exp_bwr;
        logic [15:0] exp_baddr;
        clear_stim();
        hon = 0; oon = 0;
        for (int c = 0; c < N; c++) begin
            if ($urandom_range(0, 5) == 0) hon = ~hon;
            if ($urandom_range(0, 4) == 0) oon = ~oon;
            hreq[c] = hon; oreq[c] = oon;
            hsrc[c] = ($urandom_range(0, 3) == 0) ? (16'h8000 | 16'($urandom_range(0, 16'h1FFF)))
                                                  : 16'($urandom_range(0, 16'h7FFF));
            hdst[c] = 16'h8000 | 16'($urandom_range(0, 16'h1FFF));
            osrc[c] = 16'($urandom); oidx[c] = 8'($urandom_range(0, 8'h9F));
            creq[c] = 1'($urandom_range(0, 1)); cwr[c] = 1'($urandom_range(0, 1));
            caddr[c] = ($urandom_range(0, 3) == 0) ? 16'hFF80 + 16'($urandom_range(0, 127))
                                                   : 16'($urandom_range(0, 16'hFF7F));
            cwdata[c] = 8'($urandom);
        end
        build_model(N);
        do_reset();
        run(N);
        for (int c = 0; c < N; c++) begin
            hram = (caddr[c] >= 16'hFF80);
            case (exp_owner[c])
                1: begin
                    exp_baddr = hsrc[c];
                    exp_brd = exp_rd[c] && (hsrc[c][15:13] != 3'b100);
                    exp_bwr = 0;
                end
                2: begin
                    exp_baddr = osrc[c];
                    exp_brd = exp_rd[c];
                    exp_bwr = 0;
                end
                default: begin
                    exp_baddr = (creq[c] && !hram) ? caddr[c] : 16'h0000;
                    exp_brd = creq[c] && !hram && !cwr[c];
                    exp_bwr = creq[c] && !hram && cwr[c];
                end
            endcase
            checks++;
            if (ob_grant[c] !== 2'(exp_owner[c]) || ob_vwe[c] !== exp_vwe[c] || ob_hack[c] !== exp_vwe[c] ||
                ob_owe[c] !== exp_owe[c] || ob_oack[c] !== exp_owe[c]) begin
                failures++;
                $display("[TB] FAIL random_owner c=%0d grant=%0d vwe=%b hack=%b owe=%b oack=%b required %0d %b %b %b %b",
                         c, ob_grant[c], ob_vwe[c], ob_hack[c], ob_owe[c], ob_oack[c],
                         exp_owner[c], exp_vwe[c], exp_vwe[c], exp_owe[c], exp_owe[c]);
            end
            checks++;
            if (ob_brd[c] !== exp_brd || ob_bwr[c] !== exp_bwr || ob_baddr[c] !== exp_baddr ||
                ob_stall[c] !== (creq[c] && !hram && exp_owner[c] != 0)) begin
                failures++;
                $display("[TB] FAIL random_bus c=%0d rd=%b wr=%b addr=%h stall=%b required %b %b %h %b",
                         c, ob_brd[c], ob_bwr[c], ob_baddr[c], ob_stall[c], exp_brd, exp_bwr, exp_baddr,
                         creq[c] && !hram && exp_owner[c] != 0);
            end
            if (exp_vwe[c] || exp_owe[c]) begin
                checks++;
                if ((exp_vwe[c] && (ob_vaddr[c] !== exp_vaddr[c] || ob_vdata[c] !== exp_vdata[c])) ||
                    (exp_owe[c] && (ob_oaddr[c] !== exp_oaddr[c] || ob_odata[c] !== exp_odata[c]))) begin
                    failures++;
                    $display("[TB] FAIL random_data c=%0d vaddr=%h vdata=%h oaddr=%h odata=%h required %h %h %h %h",
                             c, ob_vaddr[c], ob_vdata[c], ob_oaddr[c], ob_odata[c],
                             exp_vaddr[c], exp_vdata[c], exp_oaddr[c], exp_odata[c]);
                end
            end
        end
    endtask

    initial begin
        seed = 8'($urandom);
        clear_stim();
        test_reset();
        test_hdma_block();
        test_oam_preempt();
        test_vram_src();
        test_cpu_hram();
        test_drop_in_rd();
        test_reset_mid();
        for (int i = 0; i < 4; i++) test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
